// File: rtl/mpu_pkg.sv
// Shared matrix-unit definitions: opcode encoding, opcode classes, dispatcher states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h4;
    localparam logic [3:0] OP_UNLOAD = 4'h6;
    localparam logic [3:0] OP_ADD    = 4'hC;
    localparam logic [3:0] OP_MULT   = 4'hF;

    typedef enum logic [1:0] {CLS_STREAM, CLS_SINGLE, CLS_NOOP} op_class_t;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT} disp_state_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        casez (op)
            OP_LOAD, OP_UNLOAD: c = CLS_STREAM;
            4'b01?1, 4'b11??:   c = CLS_SINGLE;
            default:            c = CLS_NOOP;
        endcase
        return c;
    endfunction

    // Cycles the FSM spends executing; the stream length is a block parameter.
    function automatic int unsigned op_exec_cycles(input logic [3:0] op,
                                                   input int unsigned stream_cycles);
        int unsigned n;
        case (op_class(op))
            CLS_STREAM: n = stream_cycles;
            CLS_SINGLE: n = 1;
            default:    n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy level and show-ahead head word.
// Latency: a write is visible at the head one edge after it is accepted.
// Backpressure: wr_rdy low when full; a same-cycle read does not free a slot.
module instr_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (level != LW'(DEPTH));
    assign empty  = (level == '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Queues host instructions and issues them one at a time to the matrix-unit control FSM.
// Latency: issue one edge after write at the earliest; each instruction held 1+exec cycles, then NOP.
// Backpressure: host_wr_ready = !full; DISPATCH_NOOP_FILTER_EN drops NOOP-class writes instead of queueing.
module instr_dispatcher
    import mpu_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STREAM_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_wr_valid,
    input  logic [7:0]               host_wr_data,
    output logic                     host_wr_ready,
    input  logic                     fsm_busy,
    output logic [7:0]               instr_out,
    output logic                     issue_pulse,
    output logic                     done_pulse,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     drained
);

    localparam int HCW = $clog2(STREAM_CYCLES + 1) + 1;

    disp_state_t      state;
    logic [HCW-1:0]   hold_cnt;
    logic             fifo_wr_vld;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_head;

`ifdef DISPATCH_NOOP_FILTER_EN
    assign fifo_wr_vld = host_wr_valid && (op_class(host_wr_data[3:0]) != CLS_NOOP);
`else
    assign fifo_wr_vld = host_wr_valid;
`endif

    // Issue only once the FSM reports idle; WAIT may launch directly into HOLD.
    assign fifo_pop = ((state == ST_IDLE) || (state == ST_WAIT)) && !fsm_busy && !fifo_empty;
    assign drained  = fifo_empty && (state == ST_IDLE) && !fsm_busy;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (fifo_wr_vld),
        .wr_dat (host_wr_data),
        .wr_rdy (host_wr_ready),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_head),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_out   <= 8'h00;
            hold_cnt    <= '0;
            issue_pulse <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            issue_pulse <= 1'b0;
            done_pulse  <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (!fsm_busy) begin
                        if (!fifo_empty) begin
                            instr_out   <= fifo_head;
                            hold_cnt    <= HCW'(op_exec_cycles(fifo_head[3:0], STREAM_CYCLES));
                            issue_pulse <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // fsm_busy is deliberately ignored while the instruction is held.
                    if (hold_cnt == '0) begin
                        instr_out  <= 8'h00;
                        done_pulse <= 1'b1;
                        state      <= ST_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
